uart_tx: RTL and testbench

UART transmitter that drains the transmit FIFO and serialises each byte onto the `tx` line. It sits directly downstream of the TX FIFO. It pops one word whenever the FIFO is non-empty and the transmitter is idle, then shifts the word out. The frame is a start bit, DBIT data bits LSB-first, an optional parity bit and 1 or 2 stop bits. The baud divider is internal, so the block needs only `clk` and a runtime divisor.

---
 rtl/uart_tx_if.sv | 20 ++
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// FIFO-to-transmitter handshake: empty flag and head word from the FIFO, pop strobe back to it.
interface uart_tx_if #(
   parameter int DBIT = 8
);
   logic            fifo_empty;
   logic [DBIT-1:0] fifo_data;
   logic            fifo_rd;

   modport master (
      output fifo_empty,
      output fifo_data,
      input  fifo_rd
   );

   modport slave (
      input  fifo_empty,
      input  fifo_data,
      output fifo_rd
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops one FIFO word per frame and sends start, DBIT data bits LSB-first,
// optional parity and STOP_BITS stop bits, timed by an internal 16x oversampling baud divider.
module uart_tx #(
   parameter int DBIT      = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DVSR_W    = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DVSR_W-1:0] dvsr,
   uart_tx_if.slave          fifo,
   output logic              tx,
   output logic              busy,
   output logic              tx_done_tick
);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   localparam logic [4:0] LAST_TICK      = 5'd15;
   localparam logic [4:0] LAST_STOP_TICK = 5'(16 * STOP_BITS - 1);
   localparam logic [2:0] LAST_BIT       = 3'(DBIT - 1);

   state_t            state, state_next;
   logic [DVSR_W-1:0] dvsr_reg, dvsr_next;
   logic [DVSR_W-1:0] baud_cnt, baud_next;
   logic [4:0]        tick_cnt, tick_next;
   logic [2:0]        bit_cnt, bit_next;
   logic [DBIT-1:0]   shift, shift_next;
   logic              parity_bit, parity_next;
   logic              tx_reg, tx_next;
   logic              tick;
   logic              bit_end;
   logic              pop;

   // The divisor is latched per frame so a mid-frame change to dvsr cannot stretch a bit.
   assign tick    = (state != IDLE) && (baud_cnt == dvsr_reg);
   assign bit_end = tick && (tick_cnt == LAST_TICK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         dvsr_reg   <= '0;
         baud_cnt   <= '0;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         parity_bit <= 1'b0;
         tx_reg     <= 1'b1;
      end else begin
         state      <= state_next;
         dvsr_reg   <= dvsr_next;
         baud_cnt   <= baud_next;
         tick_cnt   <= tick_next;
         bit_cnt    <= bit_next;
         shift      <= shift_next;
         parity_bit <= parity_next;
         tx_reg     <= tx_next;
      end
   end

   always_comb begin
      state_next  = state;
      dvsr_next   = dvsr_reg;
      baud_next   = baud_cnt;
      tick_next   = tick_cnt;
      bit_next    = bit_cnt;
      shift_next  = shift;
      parity_next = parity_bit;

      if (state != IDLE)
         baud_next = tick ? '0 : baud_cnt + 1'b1;
      if (tick)
         tick_next = tick_cnt + 5'd1;

      case (state)
         IDLE: begin
            baud_next = '0;
            if (pop) begin
               shift_next  = fifo.fifo_data;
               dvsr_next   = dvsr;
               parity_next = (PARITY == 2) ? ~(^fifo.fifo_data) : (^fifo.fifo_data);
               tick_next   = '0;
               bit_next    = '0;
               state_next  = START;
            end
         end
         START: begin
            if (bit_end) begin
               tick_next  = '0;
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               tick_next  = '0;
               shift_next = shift >> 1;
               bit_next   = bit_cnt + 3'd1;
               if (bit_cnt == LAST_BIT) begin
                  bit_next   = '0;
                  state_next = (PARITY != 0) ? PAR : STOP;
               end
            end
         end
         PAR: begin
            if (bit_end) begin
               tick_next  = '0;
               state_next = STOP;
            end
         end
         STOP: begin
            if (tick && (tick_cnt == LAST_STOP_TICK)) begin
               tick_next  = '0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // tx is registered from the next state so it changes exactly on the bit boundary without glitches.
   always_comb begin
      pop          = (state == IDLE) && !fifo.fifo_empty && !reset;
      busy         = (state != IDLE);
      tx_done_tick = (state == STOP) && tick && (tick_cnt == LAST_STOP_TICK);
      tx_next      = 1'b1;
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         PAR:     tx_next = parity_next;
         default: tx_next = 1'b1;
      endcase
   end

   assign fifo.fifo_rd = pop;
   assign tx           = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four parameter variants share one FIFO model; a scoreboard
// of expected frames is filled as words are queued and drained as frames appear on tx.
module tb_uart_tx;

   typedef struct {
      logic [7:0] data;
      int         par_mode;
      int         stops;
      int         dv;
   } sb_t;

   logic        clk;
   logic        reset;
   logic [10:0] dvsr;
   logic [1:0]  sel;
   logic [7:0]  fifo_mem [0:31];
   logic [4:0]  wr_ptr = '0;
   logic [4:0]  rd_ptr = '0;
   logic        fifo_has;
   logic [7:0]  fifo_head;
   logic        tx_u   [4];
   logic        busy_u [4];
   logic        done_u [4];
   logic        tx_sel, busy_sel, done_sel, rd_sel;
   sb_t         sb [$];
   int          n_checks;
   int          n_pass;

   uart_tx_if #(.DBIT(8)) fif0 ();
   uart_tx_if #(.DBIT(8)) fif1 ();
   uart_tx_if #(.DBIT(8)) fif2 ();
   uart_tx_if #(.DBIT(8)) fif3 ();

   uart_tx #(.DBIT(8), .PARITY(0), .STOP_BITS(1), .DVSR_W(11)) u0 (
      .clk(clk), .reset(reset), .dvsr(dvsr), .fifo(fif0.slave),
      .tx(tx_u[0]), .busy(busy_u[0]), .tx_done_tick(done_u[0]));
   uart_tx #(.DBIT(8), .PARITY(1), .STOP_BITS(1), .DVSR_W(11)) u1 (
      .clk(clk), .reset(reset), .dvsr(dvsr), .fifo(fif1.slave),
      .tx(tx_u[1]), .busy(busy_u[1]), .tx_done_tick(done_u[1]));
   uart_tx #(.DBIT(8), .PARITY(2), .STOP_BITS(1), .DVSR_W(11)) u2 (
      .clk(clk), .reset(reset), .dvsr(dvsr), .fifo(fif2.slave),
      .tx(tx_u[2]), .busy(busy_u[2]), .tx_done_tick(done_u[2]));
   uart_tx #(.DBIT(8), .PARITY(0), .STOP_BITS(2), .DVSR_W(11)) u3 (
      .clk(clk), .reset(reset), .dvsr(dvsr), .fifo(fif3.slave),
      .tx(tx_u[3]), .busy(busy_u[3]), .tx_done_tick(done_u[3]));

   // Only the selected variant sees a non-empty FIFO; the others stay idle.
   assign fifo_has        = (wr_ptr != rd_ptr);
   assign fifo_head       = fifo_mem[rd_ptr];
   assign fif0.fifo_empty = !(fifo_has && sel == 2'd0);
   assign fif1.fifo_empty = !(fifo_has && sel == 2'd1);
   assign fif2.fifo_empty = !(fifo_has && sel == 2'd2);
   assign fif3.fifo_empty = !(fifo_has && sel == 2'd3);
   assign fif0.fifo_data  = fifo_head;
   assign fif1.fifo_data  = fifo_head;
   assign fif2.fifo_data  = fifo_head;
   assign fif3.fifo_data  = fifo_head;
   assign rd_sel   = fif0.fifo_rd | fif1.fifo_rd | fif2.fifo_rd | fif3.fifo_rd;
   assign tx_sel   = tx_u[sel];
   assign busy_sel = busy_u[sel];
   assign done_sel = done_u[sel];

   always @(posedge clk) if (rd_sel) rd_ptr <= rd_ptr + 5'd1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int model_nbits(input sb_t r);
      return 1 + 8 + ((r.par_mode != 0) ? 1 : 0) + r.stops;
   endfunction

   function automatic logic [15:0] model_frame(input sb_t r);
      logic [15:0] f;
      int ones;
      f    = 16'hFFFF;
      f[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         f[1 + i] = r.data[i];
         if (r.data[i]) ones++;
      end
      if (r.par_mode == 1) f[9] = (ones % 2 == 1);
      if (r.par_mode == 2) f[9] = (ones % 2 == 0);
      return f;
   endfunction

   task automatic push_word(input logic [7:0] d, input int dv, input bit expect_out);
      sb_t r;
      fifo_mem[wr_ptr] = d;
      wr_ptr = wr_ptr + 5'd1;
      r.data = d;
      r.dv   = dv;
      case (sel)
         2'd1:    begin r.par_mode = 1; r.stops = 1; end
         2'd2:    begin r.par_mode = 2; r.stops = 1; end
         2'd3:    begin r.par_mode = 0; r.stops = 2; end
         default: begin r.par_mode = 0; r.stops = 1; end
      endcase
      if (expect_out) sb.push_back(r);
   endtask

   // Observes one frame starting at the fifo_rd cycle (k=0); samples each bit at its first,
   // middle and last clock and returns to the caller at the negedge after tx_done_tick.
   task automatic capture_frame(input int p, input int nb, output bit found,
         output logic [15:0] mid, output logic [15:0] edge_bad, output int done_k,
         output int extra_rd, output logic busy_pre, output logic busy_post,
         output logic gap_tx, output logic gap_rd);
      logic [15:0] beg, fin;
      int budget, w, j, pos;
      budget = nb * p + 64;
      found = 0; mid = '1; beg = '1; fin = '1; edge_bad = '0; done_k = -1; extra_rd = 0;
      busy_pre = 1'b0; busy_post = 1'b0; gap_tx = 1'b0; gap_rd = 1'b0;
      w = 0;
      while (rd_sel !== 1'b1 && w < budget) begin
         @(negedge clk);
         w++;
      end
      if (rd_sel !== 1'b1) return;
      found    = 1;
      busy_pre = busy_sel;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (k == 1) busy_post = busy_sel;
         if (done_k > 0) begin
            gap_tx = tx_sel;
            gap_rd = rd_sel;
            break;
         end
         if (rd_sel) extra_rd++;
         j   = (k - 1) / p;
         pos = (k - 1) % p;
         if (j < nb) begin
            if (pos == 0)     beg[j] = tx_sel;
            if (pos == p / 2) mid[j] = tx_sel;
            if (pos == p - 1) fin[j] = tx_sel;
         end
         if (done_sel === 1'b1) done_k = k;
      end
      edge_bad = (beg ^ mid) | (fin ^ mid);
   endtask

   task automatic test_reset();
      sel = 2'd0; dvsr = 11'd3; reset = 1'b1;
      push_word(8'hA5, 3, 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++; if (tx_sel !== 1'b1) $display("[TB] FAIL reset_tx: got %b expected 1", tx_sel); else n_pass++;
         n_checks++; if (rd_sel !== 1'b0) $display("[TB] FAIL reset_rd: got %b expected 0", rd_sel); else n_pass++;
         n_checks++; if (busy_sel !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy_sel); else n_pass++;
      end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_checks++; if (rd_sel !== 1'b1) $display("[TB] FAIL reset_first_pop: got %b expected 1", rd_sel); else n_pass++;
   endtask

   task automatic test_single_byte();
      sb_t r; bit found; logic [15:0] mid, eb, exp, mask;
      int dk, xr, nb, p; logic bp, bq, gt, gr;
      r = sb[0]; nb = model_nbits(r); p = 16 * (r.dv + 1);
      capture_frame(p, nb, found, mid, eb, dk, xr, bp, bq, gt, gr);
      r = sb.pop_front(); exp = model_frame(r); mask = (16'd1 << nb) - 16'd1;
      n_checks++; if (found !== 1'b1) $display("[TB] FAIL single_found: got %0b expected 1", found); else n_pass++;
      n_checks++; if (bp !== 1'b0 || bq !== 1'b1) $display("[TB] FAIL single_busy: got %b%b expected 01", bp, bq); else n_pass++;
      n_checks++; if ((mid & mask) !== (exp & mask)) $display("[TB] FAIL single_bits: got %h expected %h", mid & mask, exp & mask); else n_pass++;
      n_checks++; if (eb !== 16'h0) $display("[TB] FAIL single_bit_edges: got %h expected 0000", eb); else n_pass++;
      n_checks++; if (dk !== nb * p) $display("[TB] FAIL single_done_cycle: got %0d expected %0d", dk, nb * p); else n_pass++;
      n_checks++; if (xr !== 0) $display("[TB] FAIL single_extra_pop: got %0d expected 0", xr); else n_pass++;
      n_checks++; if (gt !== 1'b1 || gr !== 1'b0) $display("[TB] FAIL single_idle_after: got tx=%b rd=%b expected tx=1 rd=0", gt, gr); else n_pass++;
   endtask

   task automatic test_parity();
      sb_t r; bit found; logic [15:0] mid, eb, exp, mask;
      int dk, xr, nb, p; logic bp, bq, gt, gr;
      for (int s = 1; s <= 2; s++) begin
         sel = 2'(s); dvsr = 11'd3;
         push_word(8'hA5, 3, 1);
         #1;
         r = sb[0]; nb = model_nbits(r); p = 16 * (r.dv + 1);
         capture_frame(p, nb, found, mid, eb, dk, xr, bp, bq, gt, gr);
         r = sb.pop_front(); exp = model_frame(r); mask = (16'd1 << nb) - 16'd1;
         n_checks++; if (found !== 1'b1) $display("[TB] FAIL parity%0d_found: got %0b expected 1", s, found); else n_pass++;
         n_checks++; if (bp !== 1'b0 || bq !== 1'b1) $display("[TB] FAIL parity%0d_busy: got %b%b expected 01", s, bp, bq); else n_pass++;
         n_checks++; if ((mid & mask) !== (exp & mask)) $display("[TB] FAIL parity%0d_bits: got %h expected %h", s, mid & mask, exp & mask); else n_pass++;
         n_checks++; if (mid[9] !== exp[9]) $display("[TB] FAIL parity%0d_bit: got %b expected %b", s, mid[9], exp[9]); else n_pass++;
         n_checks++; if (eb !== 16'h0) $display("[TB] FAIL parity%0d_bit_edges: got %h expected 0000", s, eb); else n_pass++;
         n_checks++; if (dk !== 704) $display("[TB] FAIL parity%0d_done_cycle: got %0d expected 704", s, dk); else n_pass++;
         n_checks++; if (xr !== 0 || gr !== 1'b0) $display("[TB] FAIL parity%0d_pops: got extra=%0d gap_rd=%b expected 0 0", s, xr, gr); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      sb_t r; bit found; logic [15:0] mid, eb, exp, mask;
      int dk, xr, nb, p; logic bp, bq, gt, gr;
      sel = 2'd0; dvsr = 11'd0;
      push_word(8'h00, 0, 1);
      push_word(8'hFF, 0, 1);
      push_word(8'h3C, 0, 1);
      #1;
      for (int f = 0; f < 3; f++) begin
         r = sb[0]; nb = model_nbits(r); p = 16 * (r.dv + 1);
         capture_frame(p, nb, found, mid, eb, dk, xr, bp, bq, gt, gr);
         r = sb.pop_front(); exp = model_frame(r); mask = (16'd1 << nb) - 16'd1;
         n_checks++; if (found !== 1'b1) $display("[TB] FAIL b2b%0d_found: got %0b expected 1", f, found); else n_pass++;
         n_checks++; if (bp !== 1'b0 || bq !== 1'b1) $display("[TB] FAIL b2b%0d_busy: got %b%b expected 01", f, bp, bq); else n_pass++;
         n_checks++; if ((mid & mask) !== (exp & mask)) $display("[TB] FAIL b2b%0d_bits: got %h expected %h", f, mid & mask, exp & mask); else n_pass++;
         n_checks++; if (eb !== 16'h0) $display("[TB] FAIL b2b%0d_bit_edges: got %h expected 0000", f, eb); else n_pass++;
         n_checks++; if (dk !== nb * p) $display("[TB] FAIL b2b%0d_done_cycle: got %0d expected %0d", f, dk, nb * p); else n_pass++;
         n_checks++; if (xr !== 0) $display("[TB] FAIL b2b%0d_extra_pop: got %0d expected 0", f, xr); else n_pass++;
         n_checks++; if (gt !== 1'b1) $display("[TB] FAIL b2b%0d_gap_tx: got %b expected 1", f, gt); else n_pass++;
         n_checks++; if (gr !== (f < 2)) $display("[TB] FAIL b2b%0d_next_pop: got %b expected %b", f, gr, (f < 2)); else n_pass++;
      end
   endtask

   task automatic test_dvsr_change_two_stop();
      sb_t r; bit found; logic [15:0] mid, eb, exp, mask;
      int dk, xr, nb, p; logic bp, bq, gt, gr;
      sel = 2'd3; dvsr = 11'd3;
      push_word(8'h5A, 3, 1);
      push_word(8'hC3, 7, 1);
      #1;
      fork
         begin
            repeat (200) @(negedge clk);
            dvsr = 11'd7;
         end
      join_none
      for (int f = 0; f < 2; f++) begin
         r = sb[0]; nb = model_nbits(r); p = 16 * (r.dv + 1);
         capture_frame(p, nb, found, mid, eb, dk, xr, bp, bq, gt, gr);
         r = sb.pop_front(); exp = model_frame(r); mask = (16'd1 << nb) - 16'd1;
         n_checks++; if (found !== 1'b1) $display("[TB] FAIL dvsr%0d_found: got %0b expected 1", f, found); else n_pass++;
         n_checks++; if ((mid & mask) !== (exp & mask)) $display("[TB] FAIL dvsr%0d_bits: got %h expected %h", f, mid & mask, exp & mask); else n_pass++;
         n_checks++; if (eb !== 16'h0) $display("[TB] FAIL dvsr%0d_bit_edges: got %h expected 0000", f, eb); else n_pass++;
         n_checks++; if (dk !== nb * p) $display("[TB] FAIL dvsr%0d_done_cycle: got %0d expected %0d", f, dk, nb * p); else n_pass++;
         n_checks++; if (xr !== 0) $display("[TB] FAIL dvsr%0d_extra_pop: got %0d expected 0", f, xr); else n_pass++;
         n_checks++; if (gr !== (f == 0)) $display("[TB] FAIL dvsr%0d_next_pop: got %b expected %b", f, gr, (f == 0)); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_frame();
      int done_seen, rd_seen, tx_low, busy_seen;
      sel = 2'd0; dvsr = 11'd3;
      push_word(8'h07, 3, 0);
      #1;
      n_checks++; if (rd_sel !== 1'b1) $display("[TB] FAIL midreset_pop: got %b expected 1", rd_sel); else n_pass++;
      repeat (289) @(negedge clk);
      n_checks++; if (tx_sel !== 1'b0) $display("[TB] FAIL midreset_data_bit3: got %b expected 0", tx_sel); else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_checks++; if (tx_sel !== 1'b1) $display("[TB] FAIL midreset_tx_async: got %b expected 1", tx_sel); else n_pass++;
      n_checks++; if (busy_sel !== 1'b0) $display("[TB] FAIL midreset_busy_async: got %b expected 0", busy_sel); else n_pass++;
      done_seen = 0; rd_seen = 0; tx_low = 0; busy_seen = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (done_sel) done_seen++;
         if (rd_sel) rd_seen++;
         if (!tx_sel) tx_low++;
         if (busy_sel) busy_seen++;
      end
      n_checks++; if (done_seen !== 0) $display("[TB] FAIL midreset_done: got %0d expected 0", done_seen); else n_pass++;
      n_checks++; if (rd_seen !== 0) $display("[TB] FAIL midreset_reread: got %0d expected 0", rd_seen); else n_pass++;
      n_checks++; if (tx_low !== 0) $display("[TB] FAIL midreset_tx_idle: got %0d low cycles expected 0", tx_low); else n_pass++;
      n_checks++; if (busy_seen !== 0) $display("[TB] FAIL midreset_busy_idle: got %0d busy cycles expected 0", busy_seen); else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_single_byte();
      test_parity();
      test_back_to_back();
      test_dvsr_change_two_stop();
      test_reset_mid_frame();
      n_checks++; if (rd_ptr !== wr_ptr) $display("[TB] FAIL total_pops: got rd_ptr=%0d expected %0d", rd_ptr, wr_ptr); else n_pass++;
      n_checks++; if (sb.size() !== 0) $display("[TB] FAIL scoreboard_drained: got %0d left expected 0", sb.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
